// File: rtl/iram_pkg.sv
// iram_pkg: shared sizes, NOP encoding and sequencer states for the instruction RAM.
package iram_pkg;
    localparam int IRAM_WORDS = 128;
    localparam int IRAM_AW    = 7;
    localparam int IRAM_DW    = 16;
    localparam logic [15:0] NOP = 16'h0000;
    typedef enum logic [1:0] {CLEAR = 2'd0, RUN = 2'd1, LOAD = 2'd2} iram_state_t;
endpackage

// File: rtl/iram_array.sv
// iram_array: instruction storage with one synchronous write port and one asynchronous read port.
module iram_array #(
    parameter int WORDS = 128,
    parameter int AW    = 7,
    parameter int DW    = 16
) (
    input  logic          CLK,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [WORDS];

    always_ff @(posedge CLK)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/iram_ctrl.sv
// iram_ctrl: clears the instruction RAM after reset, serves CPU fetches, and
// hands the RAM to the program loader while stalling the CPU.
module iram_ctrl
    import iram_pkg::*;
#(
    parameter int WORDS = IRAM_WORDS,
    parameter int AW    = IRAM_AW,
    parameter int DW    = IRAM_DW
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [AW:0]   ADDR,
    output logic [DW-1:0] Q,
    output logic          STALL,
    output logic          MISALIGN,
    output logic          RESTART,
    output logic          READY,
    input  logic          LD_REQ,
    output logic          LD_GNT,
    input  logic          LD_WE,
    input  logic [AW-1:0] LD_ADDR,
    input  logic [DW-1:0] LD_DATA,
    output logic [7:0]    LD_COUNT
);
    iram_state_t   r_state;
    logic [AW-1:0] r_ptr;
    logic          r_restart, r_ready, r_gnt;
    logic [7:0]    r_count;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata, w_rdata;

    // Clear pointer owns the write port in CLEAR; the loader only while granted.
    assign w_we    = !RESET && (r_state == CLEAR || (r_state == LOAD && LD_WE));
    assign w_waddr = r_state == CLEAR ? r_ptr : LD_ADDR;
    assign w_wdata = r_state == CLEAR ? DW'(NOP) : LD_DATA;

    iram_array #(.WORDS(WORDS), .AW(AW), .DW(DW)) u_array (
        .CLK     (CLK),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (ADDR[AW:1]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= CLEAR;
            r_ptr     <= '0;
            r_restart <= 1'b0;
            r_ready   <= 1'b0;
            r_gnt     <= 1'b0;
            r_count   <= '0;
        end else begin
            r_restart <= 1'b0;
            if (r_state == CLEAR) begin
                r_ptr <= r_ptr + 1'b1;
                if (r_ptr == AW'(WORDS - 1)) begin
                    r_state   <= RUN;
                    r_ready   <= 1'b1;
                    r_restart <= 1'b1;
                end
            end else if (r_state == RUN) begin
                if (LD_REQ) begin
                    r_state <= LOAD;
                    r_gnt   <= 1'b1;
                    r_count <= '0;
                end
            end else begin
                if (LD_WE && r_count != 8'hFF) r_count <= r_count + 1'b1;
                if (!LD_REQ) begin
                    r_state   <= RUN;
                    r_gnt     <= 1'b0;
                    r_restart <= 1'b1;
                end
            end
        end
    end

    assign Q        = r_state == RUN ? w_rdata : '0;
    assign STALL    = r_state != RUN;
    assign MISALIGN = r_state == RUN && ADDR[0];
    assign RESTART  = r_restart;
    assign READY    = r_ready;
    assign LD_GNT   = r_gnt;
    assign LD_COUNT = r_count;
endmodule
